dft_out_capture: RTL and testbench

//  Downstream stage of the streaming DFT core. Captures each 32-word output frame
//  (4 x 16-bit samples per word) that follows the core's next_out pulse.

---
 rtl/dft_out_capture_pkg.sv | 23 ++
 rtl/dft_out_capture_bank.sv | 36 +++
 rtl/dft_out_capture.sv | 204 ++++++++++++++++++++
 tb/tb_dft_out_capture.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_out_capture_pkg.sv
// Shared constants and capture-state encoding for the DFT output capture stage.
package dft_out_capture_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int LANES       = 4;
  localparam int FRAME_WORDS = 32;
  localparam int DATA_W      = LANES * SAMPLE_W;
  localparam int WORD_AW     = $clog2(FRAME_WORDS);

  localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(FRAME_WORDS - 1);
  localparam logic [WORD_AW-1:0] WORD_INC  = WORD_AW'(1);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_CAPT = 2'd1,
    C_DROP = 2'd2
  } cap_state_t;

  function automatic logic is_last_word(input logic [WORD_AW-1:0] idx);
    return (idx == LAST_WORD);
  endfunction

endpackage

// File: rtl/dft_out_capture_bank.sv
// One frame bank: FRAME_WORDS x DATA_W RAM, single write port, registered read.
module dft_frame_bank
  import dft_out_capture_pkg::*;
(
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               we,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               re,
  input  logic [WORD_AW-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem_r [FRAME_WORDS];
  logic [DATA_W-1:0] rdata_r;

  // Storage array; contents are don't-care until the bank is marked full.
  always_ff @(posedge wb_clk_i) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register holds its value unless a new read is issued.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dft_out_capture.sv
// Captures DFT output frames into a ping-pong buffer and drains them as a
// 64-bit valid/ready stream with frame-ready, overflow and protocol status.
module dft_out_capture
  import dft_out_capture_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              next_out_i,
  input  logic [DATA_W-1:0] y_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              frame_rdy_o,
  output logic              overflow_o,
  output logic              proto_err_o,
  input  logic              clr_i,
  output logic [15:0]       frame_cnt_o
);

  cap_state_t         state_r;
  cap_state_t         state_s;
  logic [WORD_AW-1:0] wr_idx_r;
  logic               wptr_r;
  logic               rptr_r;
  logic [1:0]         full_r;
  logic [1:0]         full_s;
  logic               frame_rdy_r;
  logic [WORD_AW-1:0] rd_idx_r;
  logic               rd_done_r;
  logic               valid_r;
  logic               last_r;
  logic               overflow_r;
  logic               proto_err_r;
  logic [15:0]        frame_cnt_r;

  logic               free_s;
  logic               xfer_s;
  logic               release_s;
  logic               issue_s;
  logic               cap_done_s;
  logic               ovf_set_s;
  logic               perr_set_s;
  logic               cap_we_s;
  logic [1:0]         we_s;
  logic [1:0]         re_s;
  logic [DATA_W-1:0]  rdata0_s;
  logic [DATA_W-1:0]  rdata1_s;

  // A bank released this cycle is already free for an incoming frame.
  assign xfer_s    = valid_r & m_ready_i;
  assign release_s = xfer_s & last_r;
  assign issue_s   = full_r[rptr_r] & ~rd_done_r & (~valid_r | m_ready_i);
  assign free_s    = ~full_r[wptr_r] | (release_s & (rptr_r == wptr_r));
  assign cap_we_s  = (state_r == C_CAPT);

  assign we_s[0] = cap_we_s & (wptr_r == 1'b0);
  assign we_s[1] = cap_we_s & (wptr_r == 1'b1);
  assign re_s[0] = issue_s & (rptr_r == 1'b0);
  assign re_s[1] = issue_s & (rptr_r == 1'b1);

  // Capture FSM next-state and event decode.
  always_comb begin
    state_s    = state_r;
    ovf_set_s  = 1'b0;
    perr_set_s = 1'b0;
    cap_done_s = 1'b0;
    case (state_r)
      C_IDLE: begin
        if (next_out_i) begin
          if (free_s) begin
            state_s = C_CAPT;
          end else begin
            state_s   = C_DROP;
            ovf_set_s = 1'b1;
          end
        end else begin
          state_s = C_IDLE;
        end
      end
      C_CAPT: begin
        perr_set_s = next_out_i;
        if (is_last_word(wr_idx_r)) begin
          state_s    = C_IDLE;
          cap_done_s = 1'b1;
        end else begin
          state_s = C_CAPT;
        end
      end
      C_DROP: begin
        perr_set_s = next_out_i;
        if (is_last_word(wr_idx_r)) begin
          state_s = C_IDLE;
        end else begin
          state_s = C_DROP;
        end
      end
      default: begin
        state_s = C_IDLE;
      end
    endcase
  end

  // Bank occupancy: release and capture completion always target different banks.
  always_comb begin
    full_s = full_r;
    if (release_s) begin
      full_s[rptr_r] = 1'b0;
    end else begin
      full_s = full_r;
    end
    if (cap_done_s) begin
      full_s[wptr_r] = 1'b1;
    end else begin
      full_s[wptr_r] = full_s[wptr_r];
    end
  end

  // Capture state, word counter and write pointer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= C_IDLE;
      wr_idx_r    <= {WORD_AW{1'b0}};
      wptr_r      <= 1'b0;
      full_r      <= 2'b00;
      frame_rdy_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_idx_r    <= (state_r == C_IDLE) ? {WORD_AW{1'b0}} : (wr_idx_r + WORD_INC);
      wptr_r      <= cap_done_s ? ~wptr_r : wptr_r;
      full_r      <= full_s;
      frame_rdy_r <= |full_s;
    end
  end

  // Drain side: one read in flight, stalls hold the output register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_idx_r    <= {WORD_AW{1'b0}};
      rd_done_r   <= 1'b0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      rptr_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      if (issue_s) begin
        valid_r   <= 1'b1;
        last_r    <= is_last_word(rd_idx_r);
        rd_idx_r  <= rd_idx_r + WORD_INC;
        rd_done_r <= is_last_word(rd_idx_r);
      end else if (xfer_s) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
      if (release_s) begin
        rd_done_r   <= 1'b0;
        rptr_r      <= ~rptr_r;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  // Sticky status; a same-cycle set beats the clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      overflow_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_set_s  | (overflow_r  & ~clr_i);
      proto_err_r <= perr_set_s | (proto_err_r & ~clr_i);
    end
  end

  dft_frame_bank u_bank0 (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .we       (we_s[0]),
    .waddr    (wr_idx_r),
    .wdata    (y_i),
    .re       (re_s[0]),
    .raddr    (rd_idx_r),
    .rdata    (rdata0_s)
  );

  dft_frame_bank u_bank1 (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .we       (we_s[1]),
    .waddr    (wr_idx_r),
    .wdata    (y_i),
    .re       (re_s[1]),
    .raddr    (rd_idx_r),
    .rdata    (rdata1_s)
  );

  assign m_valid_o   = valid_r;
  assign m_last_o    = last_r;
  assign m_data_o    = rptr_r ? rdata1_s : rdata0_s;
  assign frame_rdy_o = frame_rdy_r;
  assign overflow_o  = overflow_r;
  assign proto_err_o = proto_err_r;
  assign frame_cnt_o = frame_cnt_r;

endmodule

// File: tb/tb_dft_out_capture.sv
// Directed/randomized bench for dft_out_capture with a frame-queue scoreboard.
module tb_dft_out_capture;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        next_out_i;
  logic [63:0] y_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [63:0] m_data_o;
  logic        m_last_o;
  logic        frame_rdy_o;
  logic        overflow_o;
  logic        proto_err_o;
  logic        clr_i;
  logic [15:0] frame_cnt_o;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  logic [64:0] exp_q [$];

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  dft_out_capture dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .next_out_i  (next_out_i),
    .y_i         (y_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .frame_rdy_o (frame_rdy_o),
    .overflow_o  (overflow_o),
    .proto_err_o (proto_err_o),
    .clr_i       (clr_i),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transfer must match the oldest captured word; stalls must hold.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'd0, m_valid_o}, 64'd1);
        chk("hold_data", m_data_o, prev_data);
        chk("hold_last", {63'd0, m_last_o}, {63'd0, prev_last});
      end
      if (m_valid_o && m_ready_i) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", {63'd0, m_valid_o}, 64'd0);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          chk("beat_data", m_data_o, e[63:0]);
          chk("beat_last", {63'd0, m_last_o}, {63'd0, e[64]});
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end
  end

  task automatic start_frame();
    @(posedge wb_clk_i); #1;
    next_out_i = 1'b1;
  endtask

  task automatic send_words(input bit capt, input bit ramp, input int glitch,
                            input int stop, input bit glitch_clr);
    for (int w = 0; w < 32; w++) begin
      @(posedge wb_clk_i); #1;
      next_out_i = (w == glitch);
      clr_i      = (w == glitch) && glitch_clr;
      y_i        = ramp ? {4{w[15:0]}} : {$urandom(), $urandom()};
      if (w == stop) begin
        wb_rst_i = 1'b1;
        break;
      end
      if (capt) exp_q.push_back({(w == 31), y_i});
    end
  endtask

  // mode 0: ready high, 1: toggle every cycle, 2: random
  task automatic drain(input int mode);
    for (int i = 0; i < 800 && !(exp_q.size() == 0 && !m_valid_o); i++) begin
      @(posedge wb_clk_i); #1;
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = ~m_ready_i;
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    m_ready_i = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge wb_clk_i); #1;
    clr_i = 1'b1;
    @(posedge wb_clk_i); #1;
    clr_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, m_valid_o}, 64'd0);
    chk({tag, "_last"}, {63'd0, m_last_o}, 64'd0);
    chk({tag, "_data"}, m_data_o, 64'd0);
    chk({tag, "_rdy"}, {63'd0, frame_rdy_o}, 64'd0);
    chk({tag, "_ovf"}, {63'd0, overflow_o}, 64'd0);
    chk({tag, "_perr"}, {63'd0, proto_err_o}, 64'd0);
    chk({tag, "_cnt"}, {48'd0, frame_cnt_o}, 64'd0);
  endtask

  initial begin
    bit   found;
    int   base;
    wb_rst_i   = 1'b1;
    next_out_i = 1'b0;
    y_i        = 64'd0;
    m_ready_i  = 1'b0;
    clr_i      = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk_all_zero("reset");
    wb_rst_i = 1'b0;

    // 1: single ramp frame, valid latency
    m_ready_i = 1'b1;
    start_frame();
    send_words(1'b1, 1'b1, -1, -1, 1'b0);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("lat_valid_c1", {63'd0, m_valid_o}, 64'd0);
    @(negedge wb_clk_i);
    chk("lat_valid_c2", {63'd0, m_valid_o}, 64'd1);
    drain(0);
    chk("t1_cnt", {48'd0, frame_cnt_o}, 64'd1);
    chk("t1_rdy", {63'd0, frame_rdy_o}, 64'd0);

    // 2: backpressure, ready toggling
    m_ready_i = 1'b0;
    start_frame();
    send_words(1'b1, 1'b0, -1, -1, 1'b0);
    base = xfers;
    drain(1);
    chk("t2_xfers", 64'(xfers - base), 64'd32);
    chk("t2_cnt", {48'd0, frame_cnt_o}, 64'd2);

    // 3: ping-pong fill, third frame dropped
    m_ready_i = 1'b0;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      send_words(f < 2, 1'b0, -1, -1, 1'b0);
    end
    @(negedge wb_clk_i);
    chk("t3_ovf", {63'd0, overflow_o}, 64'd1);
    chk("t3_rdy", {63'd0, frame_rdy_o}, 64'd1);
    chk("t3_valid", {63'd0, m_valid_o}, 64'd1);
    chk("t3_stall_data", m_data_o, exp_q[0][63:0]);
    chk("t3_qlen", 64'(exp_q.size()), 64'd64);
    drain(0);
    chk("t3_cnt", {48'd0, frame_cnt_o}, 64'd4);
    chk("t3_ovf_sticky", {63'd0, overflow_o}, 64'd1);
    pulse_clr();
    chk("t3_ovf_clr", {63'd0, overflow_o}, 64'd0);

    // 4: next_out coincides with last-beat release while both banks full
    m_ready_i = 1'b0;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      send_words(1'b1, 1'b0, -1, -1, 1'b0);
    end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge wb_clk_i); #1;
      m_ready_i = 1'b1;
      if (m_valid_o && m_last_o) begin
        next_out_i = 1'b1;
        found = 1'b1;
      end
    end
    chk("t4_sync_found", {63'd0, found}, 64'd1);
    send_words(1'b1, 1'b0, -1, -1, 1'b0);
    drain(0);
    chk("t4_ovf", {63'd0, overflow_o}, 64'd0);
    chk("t4_perr", {63'd0, proto_err_o}, 64'd0);
    chk("t4_cnt", {48'd0, frame_cnt_o}, 64'd7);

    // 5: next_out mid-capture together with clr; set must win
    m_ready_i = 1'b1;
    start_frame();
    send_words(1'b1, 1'b0, 10, -1, 1'b1);
    @(negedge wb_clk_i);
    chk("t5_perr", {63'd0, proto_err_o}, 64'd1);
    drain(2);
    chk("t5_cnt", {48'd0, frame_cnt_o}, 64'd8);
    pulse_clr();
    chk("t5_perr_clr", {63'd0, proto_err_o}, 64'd0);

    // 6: reset at capture word 15 with one bank full
    m_ready_i = 1'b0;
    start_frame();
    send_words(1'b1, 1'b0, -1, -1, 1'b0);
    start_frame();
    send_words(1'b0, 1'b1, 5, 15, 1'b0);
    @(negedge wb_clk_i);
    chk("t6_perr_pre", {63'd0, proto_err_o}, 64'd1);
    chk("t6_rdy_pre", {63'd0, frame_rdy_o}, 64'd1);
    @(posedge wb_clk_i); #1;
    wb_rst_i   = 1'b0;
    next_out_i = 1'b0;
    exp_q.delete();
    @(negedge wb_clk_i);
    chk_all_zero("t6_rst");
    m_ready_i = 1'b1;
    start_frame();
    send_words(1'b1, 1'b1, -1, -1, 1'b0);
    drain(0);
    chk("t6_cnt", {48'd0, frame_cnt_o}, 64'd1);
    chk("t6_rdy", {63'd0, frame_rdy_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
